pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline register set (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-bar enable and flush, PC enable and redirect, and the sticky halt.
- Handles I-cache and D-cache waits, load-use stalls, taken control transfers resolved at EX/MEM, and halt drain.
- Keeps saturating stall and flush event counters for debug.

Parameters:
CNT_W, 16, width of the stall and flush event counters
REG_W, 5, register-select width (matches regbits_t)

Ports:
CLK  in  1  clock; the only clock in the block
RST  in  1  synchronous, active-high reset
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
rs_id  in  REG_W  rs field of the IF/ID instruction
rt_id  in  REG_W  rt field of the IF/ID instruction
dREN_ex  in  1  ID/EX holds a load
rt_ex  in  REG_W  ID/EX rt, the load destination
dREN_mem, dWEN_mem  in  1 each  EX/MEM holds a load or store
beq_mem, bne_mem, zero_mem, j_mem, jal_mem, JR_mem  in  1 each  EX/MEM control-transfer flags
halt_mem  in  1  EX/MEM halt_or
halt_wb  in  1  MEM/WB halt_or
pc_en  out  1  PC register update enable
pc_redirect  out  1  PC takes the EX/MEM target instead of PC+4
en  out  4  per-bar enable; bit0 = IF/ID ... bit3 = MEM/WB
flush  out  4  per-bar flush (bubble loaded on enable); same bit order
halt  out  1  sticky halted indication
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 in RUN or DWAIT
flush_cnt  out  CNT_W  saturating count of redirects

Behaviour:
Interface: one clock; reset is synchronous and active-high (CLK, RST).

Reset (RST=1 at a CLK edge):
- state=RUN, halt=0, counters=0.
- Outputs are combinational from state and inputs. In RUN with no hazard: pc_en=ihit, en=4'b1111, flush=0.
- RST wins over every other event, including mid-DWAIT and in HALTED.

State machine RUN / DWAIT / DRAIN / HALTED. Priority within RUN, highest first:
1. Memory wait: (dREN_mem|dWEN_mem) & !dhit.
   - en=0, pc_en=0, flush=0. Whole pipe frozen.
   - Next state DWAIT.
2. Halt: halt_mem.
   - flush=4'b0111, en=4'b1111, pc_en=0.
   - Next state DRAIN.
3. Taken transfer: take = beq_mem&zero_mem | bne_mem&!zero_mem | j_mem | jal_mem | JR_mem.
   - pc_redirect=1, pc_en=1, flush=4'b0111, en=4'b1111.
   - flush_cnt += 1.
   - A redirect overrides load-use and i-miss in the same cycle.
4. Load-use: dREN_ex & rt_ex!=0 & (rt_ex==rs_id | rt_ex==rt_id).
   - pc_en=0, en=4'b1110 (IF/ID holds), flush=4'b0010 (bubble into ID/EX).
   - Exactly one stall cycle per hazard.
5. I-miss: !ihit.
   - pc_en=0, en=4'b1111, flush=4'b0001 (bubble into IF/ID); later stages advance.

DWAIT:
- Hold en=0, pc_en=0 while !dhit.
- On dhit: behave as RUN for that cycle, re-evaluating items 2-5, and return to RUN.
- A dhit arriving in the same cycle as the first wait detection needs no DWAIT entry; item 1 does not fire.

DRAIN:
- en=4'b1111, flush=4'b0111, pc_en=0.
- When halt_wb=1, go to HALTED.
- No stall or flush counting in DRAIN.

HALTED:
- halt=1, en=0, flush=0, pc_en=0, pc_redirect=0.
- Sticky until RST.
- Counters frozen.

Counters:
- Saturate at all-ones; no wrap.
- stall_cnt increments on every RUN or DWAIT cycle with pc_en=0.

pc_redirect is 0 in every case other than item 3.

Decomposition:
- cpu_types_pkg: add typedef pctrl_state_t (enum logic [1:0] RUN, DWAIT, DRAIN, HALTED) and localparams for the bar indices IFID=0, IDEX=1, EXMEM=2, MEMWB=3.
- Sub-module sat_counter (parameter W; inc, clr, count) instantiated twice for stall_cnt and flush_cnt.
- Hazard decode stays inline.

Test Plan:
- Reset: RST=1 for 2 cycles, ihit=1 -> en=4'b1111, flush=0, pc_en=1, halt=0, both counters 0; assert RST mid-DWAIT -> state RUN next cycle.
- Load-use: dREN_ex=1, rt_ex=5, rs_id=5 for 1 cycle -> pc_en=0, en=4'b1110, flush=4'b0010, stall_cnt=1; with rt_ex=0 -> no stall.
- D-miss: dREN_mem=1, dhit=0 for 3 cycles then dhit=1 -> en=0 for 3 cycles, en=4'b1111 on the dhit cycle, stall_cnt=3.
- Branch: beq_mem=1, zero_mem=1 together with a load-use condition -> pc_redirect=1, flush=4'b0111, no stall, flush_cnt=1; bne_mem=1, zero_mem=1 -> no redirect.
- Halt: halt_mem=1, then halt_wb=1 two cycles later -> flush=4'b0111 during drain, then halt=1, en=0; halt stays 1 for 10 cycles with ihit toggling.
- Saturation: CNT_W=2, 6 i-miss cycles -> stall_cnt holds at 3.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: controller state type, pipeline bar indices and bar-mask helper
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} pctrl_state_t;
  localparam int IFID = 0;
  localparam int IDEX = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;
  function automatic logic [3:0] bar(input int i);
    return 4'b0001 << i;
  endfunction
  localparam logic [3:0] ALL_BARS = 4'b1111;
  localparam logic [3:0] FL_FRONT = 4'b0111;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the datapath and control outputs back to it
interface pipeline_ctrl_if #(parameter int REG_W = 5, parameter int CNT_W = 16);
  logic ihit, dhit, dREN_ex, dREN_mem, dWEN_mem;
  logic beq_mem, bne_mem, zero_mem, j_mem, jal_mem, JR_mem, halt_mem, halt_wb;
  logic [REG_W-1:0] rs_id, rt_id, rt_ex;
  logic pc_en, pc_redirect, halt;
  logic [3:0] en, flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output ihit, dhit, dREN_ex, dREN_mem, dWEN_mem, beq_mem, bne_mem, zero_mem, j_mem, jal_mem, JR_mem,
           halt_mem, halt_wb, rs_id, rt_id, rt_ex,
    input  pc_en, pc_redirect, halt, en, flush, stall_cnt, flush_cnt
  );
  modport slave (
    input  ihit, dhit, dREN_ex, dREN_mem, dWEN_mem, beq_mem, bne_mem, zero_mem, j_mem, jal_mem, JR_mem,
           halt_mem, halt_wb, rs_id, rt_id, rt_ex,
    output pc_en, pc_redirect, halt, en, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  // count up on inc until saturated
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the IF/ID..MEM/WB pipeline bars
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input logic CLK,
  input logic RST,
  pipeline_ctrl_if.slave bus
);
  pctrl_state_t r_state, w_next;
  logic w_mwait, w_take, w_lu, w_pc_en, w_redirect, w_stall_inc;
  logic [3:0] w_en, w_flush;
  // a pending D-cache access keeps the pipe frozen until dhit, whether first seen in RUN or already waiting
  assign w_mwait = ((r_state == DWAIT) | bus.dREN_mem | bus.dWEN_mem) & !bus.dhit;
  assign w_take = (bus.beq_mem & bus.zero_mem) | (bus.bne_mem & !bus.zero_mem) | bus.j_mem | bus.jal_mem | bus.JR_mem;
  assign w_lu = bus.dREN_ex & (|bus.rt_ex) & ((bus.rt_ex == bus.rs_id) | (bus.rt_ex == bus.rt_id));
  assign w_stall_inc = ((r_state == RUN) | (r_state == DWAIT)) & !w_pc_en;
  // state register
  always_ff @(posedge CLK)
    if (RST) r_state <= RUN;
    else r_state <= w_next;
  // next state and pipeline controls; DWAIT with dhit re-runs the RUN priority chain
  always_comb begin
    w_next = r_state;
    w_pc_en = 1'b0;
    w_redirect = 1'b0;
    w_en = 4'b0000;
    w_flush = 4'b0000;
    case (r_state)
      RUN, DWAIT:
        if (w_mwait) w_next = DWAIT;
        else if (bus.halt_mem) begin
          w_next = DRAIN;
          w_en = ALL_BARS;
          w_flush = FL_FRONT;
        end else if (w_take) begin
          w_next = RUN;
          w_en = ALL_BARS;
          w_flush = FL_FRONT;
          w_pc_en = 1'b1;
          w_redirect = 1'b1;
        end else if (w_lu) begin
          w_next = RUN;
          w_en = ALL_BARS & ~bar(IFID);
          w_flush = bar(IDEX);
        end else begin
          w_next = RUN;
          w_en = ALL_BARS;
          w_flush = bus.ihit ? 4'b0000 : bar(IFID);
          w_pc_en = bus.ihit;
        end
      DRAIN: begin
        w_next = bus.halt_wb ? HALTED : DRAIN;
        w_en = ALL_BARS;
        w_flush = FL_FRONT;
      end
      default: w_next = HALTED;
    endcase
  end
  assign bus.pc_en = w_pc_en;
  assign bus.pc_redirect = w_redirect;
  assign bus.en = w_en;
  assign bus.flush = w_flush;
  assign bus.halt = (r_state == HALTED);
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(CLK), .rst(RST), .inc(w_stall_inc), .clr(1'b0), .count(bus.stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(CLK), .rst(RST), .inc(w_redirect), .clr(1'b0), .count(bus.flush_cnt));
endmodule
